board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 163 ++++++++++++++++
 tb/tb_board_io_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O controller: synchronised and debounced switches/buttons, press pulses,
// PWM-dimmed LEDs and a PLL-lock-qualified, stretched SoC reset.
module board_io_ctrl #(
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned BTN_WIDTH       = 1,
   parameter int unsigned LED_WIDTH       = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned RST_STRETCH     = 16,
   parameter int unsigned PWM_BITS        = 8
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 pll_locked_i,
   input  logic [SW_WIDTH-1:0]  sw_i,
   input  logic [BTN_WIDTH-1:0] btn_i,
   input  logic [LED_WIDTH-1:0] led_i,
   input  logic [PWM_BITS-1:0]  led_bright_i,
   output logic                 sys_arst_o,
   output logic [SW_WIDTH-1:0]  sw_o,
   output logic [BTN_WIDTH-1:0] btn_o,
   output logic [BTN_WIDTH-1:0] btn_press_o,
   output logic [LED_WIDTH-1:0] led_o
);

   localparam int unsigned NumCh = SW_WIDTH + BTN_WIDTH;
   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RsW   = $clog2(RST_STRETCH + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RsW-1:0] RsLast = RsW'(RST_STRETCH - 1);

   typedef enum logic [1:0] {StReset, StStretch, StRun} rst_state_e;

   logic [NumCh-1:0]     raw;
   logic [NumCh-1:0]     sync1_q, sync2_q;
   logic [NumCh-1:0]     stable_q, stable_d;
   logic [DbW-1:0]       db_cnt_q [NumCh];
   logic [DbW-1:0]       db_cnt_d [NumCh];
   logic [BTN_WIDTH-1:0] btn_dly_q, press_q;
   logic                 lock1_q, lock2_q;
   logic [PWM_BITS-1:0]  pwm_cnt_q;
   logic                 pwm_on;
   logic [LED_WIDTH-1:0] led_q;
   rst_state_e           state_q, state_d;
   logic [RsW-1:0]       rst_cnt_q, rst_cnt_d;
   logic                 sys_arst_q;

   assign raw = {btn_i, sw_i};

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lock1_q <= 1'b0;
         lock2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         lock1_q <= pll_locked_i;
         lock2_q <= lock1_q;
      end
   end

   // A channel flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NumCh; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               stable_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         stable_q <= '0;
         for (int i = 0; i < NumCh; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < NumCh; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         btn_dly_q <= '0;
         press_q   <= '0;
      end else begin
         btn_dly_q <= stable_q[SW_WIDTH +: BTN_WIDTH];
         press_q   <= stable_q[SW_WIDTH +: BTN_WIDTH] & ~btn_dly_q;
      end
   end

   // All-ones brightness is forced to full duty; otherwise one step would stay dark.
   assign pwm_on = (pwm_cnt_q < led_bright_i) || (&led_bright_i);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         pwm_cnt_q <= '0;
         led_q     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
         led_q     <= led_i & {LED_WIDTH{pwm_on}};
      end
   end

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      unique case (state_q)
         StReset: begin
            rst_cnt_d = '0;
            if (lock2_q) state_d = StStretch;
         end
         StStretch: begin
            if (!lock2_q) begin
               state_d   = StReset;
               rst_cnt_d = '0;
            end else if (rst_cnt_q == RsLast) begin
               state_d   = StRun;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RsW'(1);
            end
         end
         StRun: begin
            if (!lock2_q) state_d = StReset;
         end
         default: begin
            state_d   = StReset;
            rst_cnt_d = '0;
         end
      endcase
   end

   // Output flop tracks the next state so reset releases on the RUN entry edge.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= StReset;
         rst_cnt_q  <= '0;
         sys_arst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         sys_arst_q <= (state_d != StRun);
      end
   end

   assign sys_arst_o  = sys_arst_q;
   assign sw_o        = stable_q[SW_WIDTH-1:0];
   assign btn_o       = stable_q[SW_WIDTH +: BTN_WIDTH];
   assign btn_press_o = press_q;
   assign led_o       = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYCLES=4, RST_STRETCH=8, PWM_BITS=4.
module tb_board_io_ctrl;

   localparam int unsigned SwW  = 16;
   localparam int unsigned BtnW = 1;
   localparam int unsigned LedW = 16;
   localparam int unsigned PwmB = 4;

   logic            clk;
   logic            arst_n;
   logic            lock;
   logic [SwW-1:0]  sw;
   logic [BtnW-1:0] btn;
   logic [LedW-1:0] led;
   logic [PwmB-1:0] bright;
   logic            sys_arst;
   logic [SwW-1:0]  sw_out;
   logic [BtnW-1:0] btn_out;
   logic [BtnW-1:0] press;
   logic [LedW-1:0] led_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   board_io_ctrl #(
      .SW_WIDTH(SwW), .BTN_WIDTH(BtnW), .LED_WIDTH(LedW),
      .DEBOUNCE_CYCLES(4), .RST_STRETCH(8), .PWM_BITS(PwmB)
   ) dut (
      .clk_i(clk), .arst_n_i(arst_n), .pll_locked_i(lock), .sw_i(sw), .btn_i(btn),
      .led_i(led), .led_bright_i(bright), .sys_arst_o(sys_arst), .sw_o(sw_out),
      .btn_o(btn_out), .btn_press_o(press), .led_o(led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0; lock = 1'b0; sw = '0; btn = '0; led = 16'hFFFF; bright = 4'hF;
      repeat (3) tick();
      total_cnt++;
      if (sys_arst !== 1'b1) $display("FAIL reset_sys_arst: got %b want 1", sys_arst);
      else pass_cnt++;
      total_cnt++;
      if (sw_out !== 16'h0) $display("FAIL reset_sw: got %h want 0000", sw_out);
      else pass_cnt++;
      total_cnt++;
      if (btn_out !== 1'b0 || press !== 1'b0)
         $display("FAIL reset_btn: got btn=%b press=%b want 0 0", btn_out, press);
      else pass_cnt++;
      total_cnt++;
      if (led_out !== 16'h0) $display("FAIL reset_led: got %h want 0000", led_out);
      else pass_cnt++;
   endtask

   task automatic test_reset_release();
      bit hold_ok = 1'b1;
      lock = 1'b1;
      tick();
      arst_n = 1'b1;
      repeat (10) begin
         tick();
         if (sys_arst !== 1'b1) hold_ok = 1'b0;
      end
      total_cnt++;
      if (!hold_ok) $display("FAIL release_hold: sys_arst dropped before 11 cycles, want 1");
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sys_arst !== 1'b0) $display("FAIL release_at_11: got %b want 0", sys_arst);
      else pass_cnt++;
   endtask

   task automatic test_lock_drop();
      lock = 1'b0;
      repeat (2) tick();
      total_cnt++;
      if (sys_arst !== 1'b0) $display("FAIL lock_drop_early: got %b want 0", sys_arst);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sys_arst !== 1'b1) $display("FAIL lock_drop_at_3: got %b want 1", sys_arst);
      else pass_cnt++;
   endtask

   task automatic test_stretch_abort();
      bit hold_ok = 1'b1;
      // Synced lock falls while the stretch counter holds 5.
      lock = 1'b1;
      repeat (6) begin
         tick();
         if (sys_arst !== 1'b1) hold_ok = 1'b0;
      end
      lock = 1'b0;
      repeat (3) begin
         tick();
         if (sys_arst !== 1'b1) hold_ok = 1'b0;
      end
      lock = 1'b1;
      repeat (10) begin
         tick();
         if (sys_arst !== 1'b1) hold_ok = 1'b0;
      end
      total_cnt++;
      if (!hold_ok) $display("FAIL stretch_abort_hold: sys_arst fell early, want 1");
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sys_arst !== 1'b0) $display("FAIL stretch_restart_run: got %b want 0", sys_arst);
      else pass_cnt++;
   endtask

   task automatic test_switch();
      bit hold_ok = 1'b1;
      sw = 16'h0008;
      repeat (5) begin
         tick();
         if (sw_out !== 16'h0) hold_ok = 1'b0;
      end
      total_cnt++;
      if (!hold_ok) $display("FAIL sw_early: output changed before 6 cycles, want 0000");
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sw_out !== 16'h0008) $display("FAIL sw_rise_at_6: got %h want 0008", sw_out);
      else pass_cnt++;
      sw = 16'h0;
      repeat (6) tick();
      total_cnt++;
      if (sw_out !== 16'h0) $display("FAIL sw_fall_at_6: got %h want 0000", sw_out);
      else pass_cnt++;
      hold_ok = 1'b1;
      sw = 16'h0008;
      repeat (3) tick();
      sw = 16'h0;
      repeat (8) begin
         tick();
         if (sw_out !== 16'h0) hold_ok = 1'b0;
      end
      total_cnt++;
      if (!hold_ok) $display("FAIL sw_glitch: 3-cycle glitch reached output, want 0000");
      else pass_cnt++;
      sw = 16'hA5A5;
      repeat (5) tick();
      total_cnt++;
      if (sw_out !== 16'h0) $display("FAIL sw_multi_early: got %h want 0000", sw_out);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (sw_out !== 16'hA5A5) $display("FAIL sw_multi: got %h want a5a5", sw_out);
      else pass_cnt++;
   endtask

   task automatic test_button();
      int n_press = 0;
      int first   = -1;
      btn = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (press === 1'b1) begin
            n_press++;
            if (first < 0) first = i;
         end
      end
      total_cnt++;
      if (btn_out !== 1'b1) $display("FAIL btn_level: got %b want 1", btn_out);
      else pass_cnt++;
      total_cnt++;
      if (n_press != 1) $display("FAIL btn_press_count: got %0d want 1", n_press);
      else pass_cnt++;
      total_cnt++;
      if (first != 7) $display("FAIL btn_press_time: got cycle %0d want 7", first);
      else pass_cnt++;
      n_press = 0;
      btn = 1'b0;
      repeat (20) begin
         tick();
         if (press === 1'b1) n_press++;
      end
      total_cnt++;
      if (n_press != 0) $display("FAIL btn_release_pulse: got %0d pulses want 0", n_press);
      else pass_cnt++;
      total_cnt++;
      if (btn_out !== 1'b0) $display("FAIL btn_release_level: got %b want 0", btn_out);
      else pass_cnt++;
   endtask

   task automatic pwm_window(input logic [PwmB-1:0] b, input int want_on, input string name);
      int on  = 0;
      int bad = 0;
      bright = b;
      tick();
      repeat (32) begin
         tick();
         if (led_out === 16'hFFFF) on++;
         else if (led_out !== 16'h0) bad++;
      end
      total_cnt++;
      if (on != want_on || bad != 0)
         $display("FAIL %s: got on=%0d bad=%0d want on=%0d bad=0", name, on, bad, want_on);
      else pass_cnt++;
   endtask

   task automatic test_pwm();
      bit ok = 1'b1;
      led = 16'hFFFF;
      pwm_window(4'd4, 8, "pwm_b4");
      pwm_window(4'd1, 2, "pwm_b1");
      pwm_window(4'd15, 32, "pwm_b15");
      pwm_window(4'd0, 0, "pwm_b0");
      led = 16'h00F0;
      bright = 4'hF;
      tick();
      total_cnt++;
      if (led_out !== 16'h00F0) $display("FAIL pwm_immediate: got %h want 00f0", led_out);
      else pass_cnt++;
      repeat (16) begin
         tick();
         if (led_out !== 16'h00F0) ok = 1'b0;
      end
      total_cnt++;
      if (!ok) $display("FAIL pwm_mask: led_o left 00f0 under full brightness");
      else pass_cnt++;
      led = 16'hFFFF;
   endtask

   task automatic test_async_reset();
      btn = 1'b1;
      repeat (8) tick();
      sw = 16'h0; btn = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (sys_arst !== 1'b0 || sw_out !== 16'hA5A5 || btn_out !== 1'b1)
         $display("FAIL pre_abort: got arst=%b sw=%h btn=%b want 0 a5a5 1",
                  sys_arst, sw_out, btn_out);
      else pass_cnt++;
      arst_n = 1'b0;
      #1;
      total_cnt++;
      if (sys_arst !== 1'b1 || sw_out !== 16'h0 || btn_out !== 1'b0 || press !== 1'b0 ||
          led_out !== 16'h0)
         $display("FAIL abort_debounce: got arst=%b sw=%h btn=%b press=%b led=%h want 1 0 0 0 0",
                  sys_arst, sw_out, btn_out, press, led_out);
      else pass_cnt++;
      arst_n = 1'b1;
      repeat (6) tick();
      sw = 16'hFFFF;
      repeat (2) tick();
      total_cnt++;
      if (sys_arst !== 1'b1 || led_out !== 16'hFFFF)
         $display("FAIL pre_stretch_abort: got arst=%b led=%h want 1 ffff", sys_arst, led_out);
      else pass_cnt++;
      arst_n = 1'b0;
      #1;
      total_cnt++;
      if (sys_arst !== 1'b1 || sw_out !== 16'h0 || led_out !== 16'h0 || press !== 1'b0)
         $display("FAIL abort_stretch: got arst=%b sw=%h led=%h press=%b want 1 0 0 0",
                  sys_arst, sw_out, led_out, press);
      else pass_cnt++;
      arst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_reset_release();
      test_lock_drop();
      test_stretch_abort();
      test_switch();
      test_button();
      test_pwm();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
